// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - operand/result stream bundle for the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int SHW = $clog2(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [SHW-1:0]        in_amount;
    logic                  in_dir;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ovf;

    // producer/consumer side (testbench or upstream/downstream logic)
    modport master (
        output in_valid, in_data, in_amount, in_dir, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // shifter side
    modport slave (
        input  in_valid, in_data, in_amount, in_dir, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined logical/arithmetic/rotate/saturating barrel shifter
module pipelined_barrel_shifter #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipelined_barrel_shifter_if.slave     bus
);
    localparam int SHW   = $clog2(DATA_WIDTH);
    localparam int N     = PIPE_STAGES;
    localparam int BASE  = SHW / N;
    localparam int EXTRA = SHW % N;

    // first mux level handled by stage s; earlier stages absorb the remainder
    function automatic int stage_lo(input int s);
        return s * BASE + ((s < EXTRA) ? s : EXTRA);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] reverse(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int b = 0; b < DATA_WIDTH; b++) r[b] = d[DATA_WIDTH-1-b];
        return r;
    endfunction

    // Left shifts are done as right shifts on the bit-reversed operand, so every
    // level only ever shifts right: fill from the top or wrap for rotate.
    function automatic logic [DATA_WIDTH-1:0] shift_levels(
        input logic [DATA_WIDTH-1:0] d,
        input logic [SHW-1:0]        amt,
        input logic                  fill,
        input logic                  rot,
        input int                    lo,
        input int                    hi
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < SHW; k++) begin
            if (k >= lo && k < hi && amt[k]) begin
                if (rot) r = (r >> (1 << k)) | (r << (DATA_WIDTH - (1 << k)));
                else     r = (r >> (1 << k)) | ({DATA_WIDTH{fill}} & ~({DATA_WIDTH{1'b1}} >> (1 << k)));
            end
        end
        return r;
    endfunction

    // undo the left-shift reversal and clamp saturating left shifts that overflowed
    function automatic logic [DATA_WIDTH-1:0] finalize(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  dir,
        input logic [1:0]            mode,
        input logic                  ovf,
        input logic                  sign
    );
        logic [DATA_WIDTH-1:0] r;
        r = dir ? reverse(d) : d;
        if (dir && mode == 2'b11 && ovf)
            r = sign ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return r;
    endfunction

    logic [N-1:0]          r_valid;
    logic [DATA_WIDTH-1:0] r_data [N];
    logic [SHW-1:0]        r_amt  [N];
    logic [1:0]            r_mode [N];
    logic [N-1:0]          r_dir, r_fill, r_sign, r_ovf;

    logic [N-1:0]          w_adv;
    logic [N-1:0]          w_src_valid, w_src_dir, w_src_fill, w_src_sign, w_src_ovf;
    logic [DATA_WIDTH-1:0] w_src_data [N];
    logic [SHW-1:0]        w_src_amt  [N];
    logic [1:0]            w_src_mode [N];
    logic [DATA_WIDTH-1:0] w_nxt_data [N];

    // stage s may load when it or any later stage is empty, or the consumer takes the result
    always_comb begin
        for (int s = 0; s < N; s++) begin
            logic w_acc;
            w_acc = bus.out_ready;
            for (int j = s; j < N; j++) w_acc = w_acc | ~r_valid[j];
            w_adv[s] = w_acc;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign w_src_valid[g] = bus.in_valid;
            assign w_src_data[g]  = bus.in_dir ? reverse(bus.in_data) : bus.in_data;
            assign w_src_amt[g]   = bus.in_amount;
            assign w_src_mode[g]  = bus.in_mode;
            assign w_src_dir[g]   = bus.in_dir;
            assign w_src_fill[g]  = ~bus.in_dir & bus.in_mode[0] & bus.in_data[DATA_WIDTH-1];
            assign w_src_sign[g]  = bus.in_data[DATA_WIDTH-1];
            // any of the top amount+1 bits differing from the sign bit means signed overflow
            assign w_src_ovf[g]   = bus.in_dir & bus.in_mode[0] &
                (|((bus.in_data ^ {DATA_WIDTH{bus.in_data[DATA_WIDTH-1]}}) &
                   ~(({DATA_WIDTH{1'b1}} >> bus.in_amount) >> 1)));
        end else begin : g_rest
            assign w_src_valid[g] = r_valid[g-1];
            assign w_src_data[g]  = r_data[g-1];
            assign w_src_amt[g]   = r_amt[g-1];
            assign w_src_mode[g]  = r_mode[g-1];
            assign w_src_dir[g]   = r_dir[g-1];
            assign w_src_fill[g]  = r_fill[g-1];
            assign w_src_sign[g]  = r_sign[g-1];
            assign w_src_ovf[g]   = r_ovf[g-1];
        end

        logic [DATA_WIDTH-1:0] w_shifted;
        assign w_shifted = shift_levels(w_src_data[g], w_src_amt[g], w_src_fill[g],
                                        w_src_mode[g] == 2'b10, stage_lo(g), stage_lo(g + 1));

        if (g == N - 1) begin : g_last
            assign w_nxt_data[g] = finalize(w_shifted, w_src_dir[g], w_src_mode[g],
                                            w_src_ovf[g], w_src_sign[g]);
        end else begin : g_mid
            assign w_nxt_data[g] = w_shifted;
        end
    end

    // pipeline registers: each stage captures its predecessor (bubble or not) when allowed to advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dir   <= '0;
            r_fill  <= '0;
            r_sign  <= '0;
            r_ovf   <= '0;
            for (int s = 0; s < N; s++) begin
                r_data[s] <= '0;
                r_amt[s]  <= '0;
                r_mode[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N; s++) begin
                if (w_adv[s]) begin
                    r_valid[s] <= w_src_valid[s];
                    r_data[s]  <= w_nxt_data[s];
                    r_amt[s]   <= w_src_amt[s];
                    r_mode[s]  <= w_src_mode[s];
                    r_dir[s]   <= w_src_dir[s];
                    r_fill[s]  <= w_src_fill[s];
                    r_sign[s]  <= w_src_sign[s];
                    r_ovf[s]   <= w_src_ovf[s];
                end
            end
        end
    end

    // control copies in the output stage have no consumer
    logic w_unused;
    assign w_unused = ^{r_amt[N-1], r_mode[N-1], r_dir[N-1], r_fill[N-1], r_sign[N-1]};

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_valid[N-1];
    assign bus.out_data  = r_data[N-1];
    assign bus.out_ovf   = r_ovf[N-1];
endmodule
